// File: rtl/streaming_fifo_pkg.sv
// Width helpers and parameter legality checks for the streaming FIFO.
// Shared by streaming_fifo_v2 and its RAM.
package streaming_fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth 2 leaves a single RAM entry; keep at least one pointer bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth - 1);
    endfunction

    function automatic bit params_ok(
        input int width,
        input int depth,
        input int af,
        input int ae
    );
        return (width >= 1) && (depth >= 2) &&
               (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/streaming_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Non-power-of-two entry counts are allowed.
module streaming_fifo_ram
    import streaming_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 1023,
    parameter int AW      = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/streaming_fifo_v2.sv
// AXI-Stream FIFO with registered FWFT output and almost flags.
// Optional high-water mark: define STREAMING_FIFO_HWM_EN.
module streaming_fifo_v2
    import streaming_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
`ifdef STREAMING_FIFO_HWM_EN
    input  logic             hwm_clr,
    output logic [CW-1:0]    max_count,
`endif
    input  logic [WIDTH-1:0] in0_V_V_TDATA,
    input  logic             in0_V_V_TVALID,
    output logic             in0_V_V_TREADY,
    output logic [WIDTH-1:0] out_V_V_TDATA,
    output logic             out_V_V_TVALID,
    input  logic             out_V_V_TREADY
);

    localparam int PW                = ptr_w(DEPTH);
    localparam int RN                = DEPTH - 1;
    localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 2);
    localparam logic [CW-1:0] D_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad
        $error("streaming_fifo_v2: illegal parameters");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] ram_rdata;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             out_take;
    logic             ram_nonempty;
    logic             load_ram;
    logic             bypass;
    logic             ram_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    assign push         = in0_V_V_TVALID & in0_V_V_TREADY;
    assign pop          = out_V_V_TVALID & out_V_V_TREADY;
    assign out_take     = ~out_V_V_TVALID | pop;
    // RAM occupancy is count minus the output register word.
    assign ram_nonempty = count > CW'(out_V_V_TVALID);
    assign load_ram     = out_take & ram_nonempty;
    assign bypass       = out_take & ~ram_nonempty & push;
    assign ram_we       = push & ~bypass;
    assign count_next   = count + CW'(push) - CW'(pop);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            in0_V_V_TREADY <= 1'b0;
            out_V_V_TVALID <= 1'b0;
            out_V_V_TDATA  <= '0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
        end else begin
            count          <= count_next;
            in0_V_V_TREADY <= count_next < D_C;
            almost_full    <= count_next >= AF_C;
            almost_empty   <= count_next <= AE_C;
            if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
            if (load_ram) begin
                rd_ptr        <= ptr_inc(rd_ptr);
                out_V_V_TDATA <= ram_rdata;
            end else if (bypass) begin
                out_V_V_TDATA <= in0_V_V_TDATA;
            end
            if (out_take) out_V_V_TVALID <= ram_nonempty | push;
        end
    end

`ifdef STREAMING_FIFO_HWM_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            max_count <= '0;
        end else if (hwm_clr || count_next > max_count) begin
            max_count <= count_next;
        end
    end
`endif

    streaming_fifo_ram #(
        .WIDTH  (WIDTH),
        .ENTRIES(RN),
        .AW     (PW)
    ) u_ram (
        .clk  (ap_clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(in0_V_V_TDATA),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_streaming_fifo_v2.sv
// Randomised bench for streaming_fifo_v2 against a queue model.
// HWM checks compile only with STREAMING_FIFO_HWM_EN.
module tb_streaming_fifo_v2;

    localparam int DEPTH = 5;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          af;
    logic          ae;
    logic          hwm_clr = 1'b0;
`ifdef STREAMING_FIFO_HWM_EN
    logic [CW-1:0] max_count;
    int            max_m = 0;
`endif

    logic [7:0] q[$];
    logic [7:0] last_pop = '0;
    bit         rdy_en = 0;
    int         checks = 0;
    int         errors = 0;

    streaming_fifo_v2 #(
        .WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .count         (count),
        .almost_full   (af),
        .almost_empty  (ae),
`ifdef STREAMING_FIFO_HWM_EN
        .hwm_clr       (hwm_clr),
        .max_count     (max_count),
`endif
        .in0_V_V_TDATA (in_data),
        .in0_V_V_TVALID(in_valid),
        .in0_V_V_TREADY(in_ready),
        .out_V_V_TDATA (out_data),
        .out_V_V_TVALID(out_valid),
        .out_V_V_TREADY(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a falling edge: drive, advance the model across one
    // rising edge, return at the next falling edge.
    task automatic step(input bit v, input bit r, input logic [7:0] d,
                        output bit acc);
        bit pu, po;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        pu = v && rdy_en && (q.size() < DEPTH);
        po = r && (q.size() > 0);
        @(posedge clk);
        if (po) last_pop = q.pop_front();
        if (pu) q.push_back(d);
        rdy_en = 1;
`ifdef STREAMING_FIFO_HWM_EN
        if (hwm_clr || q.size() > max_m) max_m = q.size();
`endif
        acc = pu;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        #22;
        checks++; if (count !== 0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        checks++; if ({af, ae} !== 2'b01) begin errors++; $display("FAIL rst_flags: got af/ae %b want 01", {af, ae}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_ready: got %b want 0", in_ready); end
        @(negedge clk);
        step(0, 0, 8'h00, acc);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        bit acc;
        step(1, 1, 8'hA5, acc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data); end
        checks++; if (count !== 1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        step(0, 1, 8'h00, acc);
        checks++; if (count !== 0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h want a5", out_data); end
    endtask

    task automatic test_fill();
        bit acc;
        logic [7:0] w = 8'h01;
        repeat (DEPTH + 2) begin
            step(1, 0, w, acc);
            if (acc) w++;
            checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, q.size()); end
            checks++; if (af !== (q.size() >= AF)) begin errors++; $display("FAIL fill_af: got %b at count %0d", af, q.size()); end
            checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL fill_ready: got %b at count %0d", in_ready, q.size()); end
        end
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_full: got %0d want %0d", count, DEPTH); end
        checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL fill_head: got %h want 01", out_data); end
    endtask

    task automatic test_full_pop();
        bit acc;
        step(1, 1, 8'h06, acc);
        checks++; if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL fp_count: got %0d want %0d", count, DEPTH - 1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fp_ready: got %b want 1", in_ready); end
        checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL fp_head: got %h want 02", out_data); end
        while (q.size() > 0) begin
            step(0, 1, 8'h00, acc);
            checks++; if (out_data !== (q.size() > 0 ? q[0] : last_pop)) begin errors++; $display("FAIL fp_drain: got %h", out_data); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        bit acc;
        int words = 0;
        int cyc = 0;
        logic [7:0] exp_d;
        while (words < 10000 && cyc < 60000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), acc);
            if (acc) words++;
            cyc++;
            exp_d = (q.size() > 0) ? q[0] : last_pop;
            checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", cyc, count, q.size()); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid: cyc %0d got %b", cyc, out_valid); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", cyc, out_data, exp_d); end
            checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready: cyc %0d got %b", cyc, in_ready); end
            checks++; if (af !== (q.size() >= AF)) begin errors++; $display("FAIL rnd_af: cyc %0d got %b", cyc, af); end
            checks++; if (ae !== (q.size() <= AE)) begin errors++; $display("FAIL rnd_ae: cyc %0d got %b", cyc, ae); end
        end
        checks++; if (words < 10000) begin errors++; $display("FAIL rnd_budget: got %0d words want 10000", words); end
        while (q.size() > 0) step(0, 1, 8'h00, acc);
    endtask

    task automatic test_async_reset();
        bit acc;
        step(1, 0, 8'h11, acc);
        step(1, 0, 8'h22, acc);
        step(1, 0, 8'h33, acc);
        checks++; if (count !== 3) begin errors++; $display("FAIL ar_pre: got %0d want 3", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 0) begin errors++; $display("FAIL ar_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_ready: got %b want 0", in_ready); end
        q.delete();
        rdy_en = 0;
        last_pop = '0;
`ifdef STREAMING_FIFO_HWM_EN
        max_m = 0;
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 8'h00, acc);
        step(1, 1, 8'h3C, acc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_post_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL ar_post_data: got %h want 3c", out_data); end
        step(0, 1, 8'h00, acc);
    endtask

`ifdef STREAMING_FIFO_HWM_EN
    task automatic test_hwm();
        bit acc;
        repeat (DEPTH) step(1, 0, 8'($urandom), acc);
        while (q.size() > 0) step(0, 1, 8'h00, acc);
        checks++; if (max_count !== CW'(max_m)) begin errors++; $display("FAIL hwm_peak: got %0d want %0d", max_count, max_m); end
        step(1, 0, 8'h01, acc);
        hwm_clr = 1'b1;
        step(1, 0, 8'h02, acc);
        hwm_clr = 1'b0;
        checks++; if (max_count !== 2) begin errors++; $display("FAIL hwm_clr: got %0d want 2", max_count); end
        while (q.size() > 0) step(0, 1, 8'h00, acc);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_random();
        test_async_reset();
`ifdef STREAMING_FIFO_HWM_EN
        test_hwm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/streaming_fifo_v2.md
Name: streaming_fifo_v2

Overview:
Parametrised AXI-Stream FIFO, the next generation of the dataflow inter-layer FIFOs. It generalises width and depth and adds programmable almost-full and almost-empty flags. A registered first-word-fall-through output stage removes the combinational paths between the input and output sides. It sits between streaming compute layers and provides elastic buffering and occupancy visibility for FIFO sizing.

Parameters:
WIDTH, 8, data bits per stream word (>=1).
DEPTH, 1024, total words stored, including the output register (>=2, any integer).
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  reset, asynchronous assert, active-low
count  out  CW=$clog2(DEPTH+1)  words currently held (RAM plus output register)
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
in0_V_V_TDATA  in  WIDTH  input word
in0_V_V_TVALID  in  1  input valid
in0_V_V_TREADY  out  1  FIFO can accept
out_V_V_TDATA  out  WIDTH  output word, driven from the output register
out_V_V_TVALID  out  1  output register holds a word
out_V_V_TREADY  in  1  downstream accepts

Behaviour:
- Reset (ap_rst_n=0, asynchronous): pointers=0, count=0, out_V_V_TVALID=0, out_V_V_TDATA=0, in0_V_V_TREADY=0, almost_empty=1, almost_full=0.
- First rising edge after reset release: in0_V_V_TREADY=1.
- Push = in0_V_V_TVALID & in0_V_V_TREADY. Pop = out_V_V_TVALID & out_V_V_TREADY.
- in0_V_V_TREADY is registered, equal to (next count < DEPTH). It never depends combinationally on out_V_V_TREADY.
- Storage: a (DEPTH-1)-entry circular RAM plus a 1-word output register.
- Output register load rule, evaluated each edge:
  - If the output register is empty or popping, and the RAM is non-empty: load RAM[rd_ptr] and advance rd_ptr.
  - Else if the output register is empty or popping, the RAM is empty, and a push occurs: bypass the input word into the output register.
  - Otherwise a push writes RAM[wr_ptr] and advances wr_ptr.
- Latency: word pushed at edge k into an empty FIFO gives out_V_V_TVALID=1 after edge k, i.e. 1 cycle.
- Pointers wrap from DEPTH-2 to 0. No power-of-two requirement.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Saturation is impossible by construction.
- Full (count=DEPTH): TREADY=0. A pop in that cycle makes TREADY=1 from the next cycle; a same-cycle push is not accepted.
- Empty: TVALID=0, and TDATA holds its last value. A simultaneous push fills the output register via bypass.
- Ordering is strict FIFO. No word is lost or duplicated under any TVALID/TREADY pattern.
- almost_full and almost_empty are decoded from the registered count (glitch-free, same cycle as count).
- Reset asserted mid-stream: all contents discarded immediately. Outputs take reset values asynchronously.

Optional Feature:
Macro STREAMING_FIFO_HWM_EN.
- Defined: adds input hwm_clr (1 bit) and output max_count (CW bits), reset 0.
  - Each edge: max_count <= hwm_clr ? count_next : max(max_count, count_next).
  - Gives a high-water mark for FIFO sizing.
- Undefined: neither port nor its register exists. Behaviour is otherwise identical.

Decomposition:
- Package streaming_fifo_pkg: clog2-based width helpers (count width, pointer width), and parameter legality checks as elaboration-time assertions (DEPTH>=2, thresholds in range).
- Sub-module streaming_fifo_ram: (DEPTH-1) x WIDTH simple dual-port RAM, synchronous write, asynchronous read (LUTRAM-inferable).
- Pointer, count, bypass and flag logic stay in the top-level module.

Test Plan:
- Reset then single push of 0xA5 with out_V_V_TREADY=1: TVALID=1 the next cycle with TDATA=0xA5, count 0->1->0.
- DEPTH=4, out_V_V_TREADY=0, push 0x01..0x06: 0x01..0x04 accepted, TREADY=0 once count=4, almost_full=1 from count=2, remaining words held off.
- Full FIFO, TREADY=1 for one cycle while TVALID=1: 0x01 popped, count=3, in0_V_V_TREADY=1 the following cycle, no push in the pop cycle.
- Random TVALID/TREADY at 50%/50% for 10k words, DEPTH=5 (non-power-of-two): output sequence equals input sequence, count never exceeds 5, flags match thresholds every cycle.
- ap_rst_n pulsed low mid-stream with count=3: TVALID and count drop to 0 without a clock edge, and the first post-reset word emerges uncorrupted.
- HWM_EN build: fill to 7, drain, max_count=7; pulse hwm_clr with count=2, then max_count=2.
